// File: rtl/i2c_slave_regfile.sv
// Register file behind an I2C slave byte engine: pointer byte, auto-incrementing
// writes and reads from the I2C side, plus a concurrent single-cycle host port.
module i2c_slave_regfile #(
    parameter int               NREGS   = 16,
    parameter logic [NREGS-1:0] RO_MASK = '0,
    localparam int              AW      = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          xfer_start,
    input  logic          xfer_rw,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid_n,
    input  logic          tx_req_n,
    output logic [7:0]    tx_data,
    input  logic [AW-1:0] host_addr,
    input  logic          host_we,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          i2c_wr_pulse,
    output logic [AW-1:0] i2c_wr_addr,
    output logic          ptr_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PTR     = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_DISCARD = 3'd3;
    localparam logic [2:0] S_READ    = 3'd4;

    logic [2:0]    state;
    logic [AW-1:0] ptr;
    logic [7:0]    regs [NREGS];
    logic          rx_valid_n_q;
    logic          tx_req_n_q;

    logic rx_fall;
    logic tx_fall;
    logic ptr_ok;
    logic i2c_wr;
    logic collide;
    logic i2c_commit;

    assign rx_fall = rx_valid_n_q & ~rx_valid_n;
    assign tx_fall = tx_req_n_q & ~tx_req_n;

    // Pointer byte is legal only when every bit above the index width is zero.
    assign ptr_ok = ((rx_data >> AW) == 8'd0);

    // A restart in the same cycle as a strobe swallows the strobe.
    assign i2c_wr     = (state == S_WRITE) && rx_fall && !xfer_start && !RO_MASK[ptr];
    assign collide    = host_we && (host_addr == ptr);
    assign i2c_commit = i2c_wr && !collide;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_valid_n_q <= 1'b1;
            tx_req_n_q   <= 1'b1;
        end else begin
            rx_valid_n_q <= rx_valid_n;
            tx_req_n_q   <= tx_req_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            ptr     <= '0;
            ptr_err <= 1'b0;
        end else if (xfer_start) begin
            state   <= xfer_rw ? S_READ : S_PTR;
            ptr_err <= 1'b0;
        end else begin
            case (state)
                S_PTR: begin
                    if (rx_fall) begin
                        if (ptr_ok) begin
                            ptr   <= rx_data[AW-1:0];
                            state <= S_WRITE;
                        end else begin
                            ptr_err <= 1'b1;
                            state   <= S_DISCARD;
                        end
                    end
                end
                S_WRITE: begin
                    // Read-only targets still advance the pointer.
                    if (rx_fall)
                        ptr <= ptr + 1'b1;
                end
                S_READ: begin
                    if (tx_fall)
                        ptr <= ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Host write is applied last so it wins a same-register collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= 8'h00;
        end else begin
            if (i2c_commit)
                regs[ptr] <= rx_data;
            if (host_we)
                regs[host_addr] <= host_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data      <= 8'h00;
            host_rdata   <= 8'h00;
            i2c_wr_pulse <= 1'b0;
            i2c_wr_addr  <= '0;
        end else begin
            tx_data      <= regs[ptr];
            host_rdata   <= regs[host_addr];
            i2c_wr_pulse <= i2c_commit;
            if (i2c_commit)
                i2c_wr_addr <= ptr;
        end
    end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
Register-file back end sitting directly downstream of the I2C slave byte engine; consumes its received bytes and supplies its transmit bytes. After a write-addressed START, the first data byte is a register pointer and following bytes write registers with auto-increment. After a read-addressed START, registers are returned from the current pointer with auto-increment. A host port gives fabric logic concurrent access to the same registers.

Parameters:
NREGS, 16, number of 8-bit registers; power of two, 2..128; AW = log2(NREGS) is derived as a localparam.
RO_MASK, {NREGS{1'b0}}, bit i set = register i is read-only from I2C; host may still write it.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  asynchronous, active-high reset.
xfer_start  in  1  one-cycle pulse from slave on address-matched START/RESTART.
xfer_rw  in  1  R/W bit of that address byte; valid with xfer_start; 1 = read.
rx_data  in  8  byte received by the slave.
rx_valid_n  in  1  active-low; falling edge = rx_data valid (stable while low).
tx_req_n  in  1  active-low; falling edge = slave has taken tx_data and wants the next byte.
tx_data  out  8  byte presented to the slave for read transfers.
host_addr  in  AW  host register index.
host_we  in  1  host write enable, one cycle.
host_wdata  in  8  host write data.
host_rdata  out  8  registered read of reg[host_addr].
i2c_wr_pulse  out  1  one-cycle pulse when an I2C write commits to a register.
i2c_wr_addr  out  AW  index written; valid with i2c_wr_pulse.
ptr_err  out  1  sticky; set on out-of-range pointer byte; cleared by reset or next xfer_start.

Behaviour:
- Reset (async, high): all registers 0x00, ptr 0, state IDLE, tx_data 0x00, host_rdata 0x00, i2c_wr_pulse 0, i2c_wr_addr 0, ptr_err 0; edge-detect flops for rx_valid_n/tx_req_n set to 1 so no edge is seen after release.
- Edge detect: rx_fall = rx_valid_n_q & ~rx_valid_n; tx_fall likewise; one cycle of detection latency.
- FSM states: IDLE, PTR, WRITE, DISCARD, READ.
  - Any state: xfer_start -> PTR if xfer_rw=0, READ if xfer_rw=1; clears ptr_err; ptr unchanged. xfer_start has priority over a same-cycle rx_fall/tx_fall, which is dropped.
  - IDLE: ignores rx_fall/tx_fall.
  - PTR, rx_fall: if rx_data[7:AW]==0, ptr <= rx_data[AW-1:0], -> WRITE; else ptr unchanged, ptr_err <= 1, -> DISCARD.
  - WRITE, rx_fall: if RO_MASK[ptr]=0, reg[ptr] <= rx_data, i2c_wr_pulse=1 and i2c_wr_addr=ptr next cycle; if read-only, no write, no pulse. ptr <= ptr+1 mod NREGS in both cases (NREGS-1 wraps to 0).
  - DISCARD: rx_fall ignored until next xfer_start.
  - READ, tx_fall: ptr <= ptr+1 mod NREGS. rx_fall ignored.
- tx_data registered: tx_data <= reg[ptr] every cycle, so it reflects a ptr or register change one cycle later (two cycles after the tx_req_n edge). The slave samples no earlier than 3 clk after its request; I2C bit periods guarantee this.
- host_rdata <= reg[host_addr] every cycle (1-cycle latency).
- Same-cycle host_we and I2C write to the same register: host wins, no i2c_wr_pulse. Different registers: both commit.
- No STOP input. The pointer persists across transactions; a read after a write-with-pointer-only (START, W, ptr, RESTART, R) reads from that pointer.
- Reset mid-transaction returns everything to reset values immediately. Register contents are lost.

Test Plan:
- Write burst: xfer_start rw=0, bytes 0x03,0xAA,0xBB -> reg3=0xAA, reg4=0xBB; i2c_wr_pulse twice with addr 3 then 4; ptr=5.
- Combined read: xfer_start rw=0, byte 0x0E; xfer_start rw=1; three tx_req_n falls -> tx_data sequence reg14, reg15, reg0 (wrap); ptr=1.
- Out-of-range pointer (NREGS=16): pointer byte 0x20 then data 0x55 -> ptr_err=1, no register changes, no pulse; next xfer_start clears ptr_err.
- RO_MASK bit2 set: write ptr 0x02, data 0x11,0x22 -> reg2 unchanged, reg3=0x22, single pulse addr 3.
- Collision: host_we to reg5 with 0x77 in the same cycle an I2C write to reg5 with 0x99 commits -> reg5=0x77, no i2c_wr_pulse; host_rdata for addr5 = 0x77 one cycle later.
- Reset asserted between data bytes of a write burst -> all regs 0, state IDLE; later rx_fall without xfer_start causes no write.
